// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues start with operands; the slave reports busy/done and the result.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] d;
  logic             b_out;

  modport master (
    output start, a, b, bin,
    input  busy, done, d, b_out
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, d, b_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin, LSB first, one full-subtractor cell
// and a borrow flip-flop, with a start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             load, step, finish;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] acc_n;
  logic [CNT_W-1:0] count;
  logic             borrow, borrow_n, diff_bit;
  logic [WIDTH-1:0] d_q;
  logic             b_out_q;

  // Full-subtractor cell on the current LSBs.
  assign diff_bit = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_n = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & borrow) | (b_sr[0] & borrow);
  // The accumulator keeps only the upper WIDTH-1 bits; the final bit joins at completion.
  assign acc_n    = {diff_bit, acc};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n = state;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          busy_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count == LAST) begin
          finish  = 1'b1;
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          busy_n  = 1'b1;
        end
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          busy_n  = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      acc     <= '0;
      count   <= '0;
      borrow  <= 1'b0;
      d_q     <= '0;
      b_out_q <= 1'b0;
    end else begin
      if (load) begin
        a_sr   <= bus.a;
        b_sr   <= bus.b;
        borrow <= bus.bin;
        acc    <= '0;
        count  <= '0;
      end else if (step) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        borrow <= borrow_n;
        acc    <= acc_n[WIDTH-1:1];
        count  <= count + 1'b1;
      end
      // Result registers move only at completion, so partial bits never reach d.
      if (finish) begin
        d_q     <= acc_n;
        b_out_q <= borrow_n;
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.d     = d_q;
  assign bus.b_out = b_out_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=4 (directed + exhaustive)
// and WIDTH=8 (random); results are matched against a queue of expected values.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [4:0] q4[$];
  logic [8:0] q8[$];

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(4)) bus4 ();
  serial_subtractor_if #(.WIDTH(8)) bus8 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: each done pulse pops one expected {b_out, d}.
  always @(negedge clk) begin
    if (bus4.done) begin
      if (q4.size() == 0) check("unexpected_done4", 1, 0);
      else check("result4", {bus4.b_out, bus4.d}, q4.pop_front());
      check("busy_done_excl4", bus4.busy, 0);
    end
    if (bus8.done) begin
      if (q8.size() == 0) check("unexpected_done8", 1, 0);
      else check("result8", {bus8.b_out, bus8.d}, q8.pop_front());
    end
  end

  task automatic wait_done4(output int cycles);
    cycles = 0;
    while (!bus4.done && cycles < 20) begin
      tick();
      cycles++;
    end
    if (!bus4.done) check("timeout4", 0, 1);
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic bin, input bit expect_result);
    bus4.a     = a;
    bus4.b     = b;
    bus4.bin   = bin;
    bus4.start = 1'b1;
    if (expect_result) q4.push_back(5'({1'b0, a}) - 5'({1'b0, b}) - 5'(bin));
  endtask

  task automatic run_op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int cyc;
    drive4(a, b, bin, 1'b1);
    tick();
    bus4.start = 1'b0;
    wait_done4(cyc);
    tick();
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int cyc;
    bus8.a     = a;
    bus8.b     = b;
    bus8.bin   = bin;
    bus8.start = 1'b1;
    q8.push_back(9'({1'b0, a}) - 9'({1'b0, b}) - 9'(bin));
    tick();
    bus8.start = 1'b0;
    cyc = 0;
    while (!bus8.done && cyc < 20) begin
      tick();
      cyc++;
    end
    if (!bus8.done) check("timeout8", 0, 1);
    else check("latency8", cyc, 8);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n_done;
    int n_busy;

    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;

    // Reset for two cycles.
    rst = 1'b1;
    tick();
    tick();
    check("rst_busy", bus4.busy, 0);
    check("rst_done", bus4.done, 0);
    check("rst_d", bus4.d, 0);
    check("rst_b_out", bus4.b_out, 0);
    check("rst_d8", bus8.d, 0);
    rst = 1'b0;
    tick();

    // Basic: 5 - 3 with exact cycle-by-cycle handshake.
    drive4(4'd5, 4'd3, 1'b0, 1'b1);
    tick();
    bus4.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("basic_busy%0d", i), bus4.busy, 1);
      check($sformatf("basic_nodone%0d", i), bus4.done, 0);
      tick();
    end
    check("basic_done", bus4.done, 1);
    check("basic_busy_low", bus4.busy, 0);
    check("basic_d", bus4.d, 2);
    check("basic_b_out", bus4.b_out, 0);
    tick();
    check("basic_done_one_cycle", bus4.done, 0);
    tick();
    check("basic_d_hold", bus4.d, 2);

    // Wrap-around and borrow cases.
    run_op4(4'd3, 4'd5, 1'b0);
    check("wrap_d", bus4.d, 4'hE);
    check("wrap_b_out", bus4.b_out, 1);
    run_op4(4'd0, 4'd0, 1'b1);
    check("bin_d", bus4.d, 4'hF);
    check("bin_b_out", bus4.b_out, 1);
    run_op4(4'd9, 4'd9, 1'b0);
    check("equal_d", bus4.d, 0);
    check("equal_b_out", bus4.b_out, 0);

    // Start while busy is ignored.
    drive4(4'd8, 4'd1, 1'b0, 1'b1);
    tick();
    bus4.start = 1'b0;
    tick();
    tick();
    drive4(4'd1, 4'd8, 1'b0, 1'b0);
    tick();
    bus4.start = 1'b0;
    check("ignore_busy", bus4.busy, 1);
    tick();
    check("ignore_done", bus4.done, 1);
    check("ignore_d", bus4.d, 7);
    check("ignore_b_out", bus4.b_out, 0);
    n_done = 0;
    n_busy = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_done += int'(bus4.done);
      n_busy += int'(bus4.busy);
    end
    check("ignore_no_extra_done", n_done, 0);
    check("ignore_no_extra_busy", n_busy, 0);

    // Back-to-back with start held high; operands swapped during DONE.
    drive4(4'd6, 4'd2, 1'b0, 1'b1);
    tick();
    wait_done4(cyc);
    check("b2b_first_latency", cyc, 4);
    check("b2b_first_d", bus4.d, 4);
    drive4(4'd2, 4'd6, 1'b0, 1'b1);
    tick();
    check("b2b_reaccept_busy", bus4.busy, 1);
    wait_done4(cyc);
    check("b2b_period", cyc + 1, 5);
    check("b2b_second_d", bus4.d, 4'hC);
    check("b2b_second_b_out", bus4.b_out, 1);
    bus4.start = 1'b0;
    tick();
    check("b2b_idle", bus4.busy, 0);

    // Reset in the middle of an operation.
    drive4(4'd15, 4'd1, 1'b0, 1'b0);
    tick();
    bus4.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", bus4.busy, 0);
    check("midrst_done", bus4.done, 0);
    check("midrst_d", bus4.d, 0);
    check("midrst_b_out", bus4.b_out, 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_done += int'(bus4.done);
    end
    check("midrst_no_done", n_done, 0);
    run_op4(4'd10, 4'd4, 1'b0);
    check("post_rst_d", bus4.d, 6);
    check("post_rst_b_out", bus4.b_out, 0);

    // Exhaustive WIDTH=4 sweep; the scoreboard compares each result.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bi = 0; bi < 2; bi++)
          run_op4(4'(a), 4'(b), 1'(bi));

    // WIDTH=8 random vectors.
    for (int i = 0; i < 1000; i++)
      run_op8(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));

    tick();
    check("q4_drained", q4.size(), 0);
    check("q8_drained", q8.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
